// File: rtl/bp_pkg.sv
// Shared types for the fetch-stage branch predictor: direction-counter
// encodings, the allocation value and the default BTB entry layout.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_e;

    // New entries start weakly taken: one not-taken outcome flips them back.
    localparam ctr_e CTR_ALLOC = WT;

    localparam int BP_DW    = 32;
    localparam int BP_DEPTH = 16;
    localparam int BP_IDXW  = $clog2(BP_DEPTH);
    localparam int BP_TAGW  = BP_DW - BP_IDXW;

    typedef struct packed {
        logic               valid;
        logic [BP_TAGW-1:0] tag;
        logic [BP_DW-1:0]   target;
        ctr_e               ctr;
    } btb_entry_t;

    function automatic logic ctr_predicts_taken(input ctr_e c);
        return (c == WT) || (c == ST);
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Two-bit saturating up/down direction counter, purely combinational
// next-state function.
module bp_sat_counter
    import bp_pkg::*;
(
    input  ctr_e i_ctr,
    input  logic i_taken,
    output ctr_e o_ctr
);

    always_comb begin
        o_ctr = i_ctr;
        if (i_taken) begin
            if (i_ctr != ST) o_ctr = ctr_e'(i_ctr + 2'd1);
        end else begin
            if (i_ctr != SNT) o_ctr = ctr_e'(i_ctr - 2'd1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB branch predictor with 2-bit direction counters.
// Optional statistics counters are enabled by defining BP_STATS_EN.
module branch_predictor
    import bp_pkg::*;
#(
    parameter  int DW    = BP_DW,
    parameter  int DEPTH = BP_DEPTH,
    localparam int IDXW  = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic [DW-1:0] PCF,
    input  logic [DW-1:0] PCPlus1F,
    output logic          PredTakenF,
    output logic [DW-1:0] PredPCF,
    input  logic          StallD,
    input  logic          FlushD,
    input  logic          BranchD,
    input  logic          TakenD,
    input  logic [DW-1:0] TargetD,
    input  logic [DW-1:0] PCD,
    output logic          MispredictD,
    output logic [DW-1:0] RecoverPCD,
    output logic [31:0]   BrCount,
    output logic [31:0]   MissCount
);

    localparam int TAGW = DW - IDXW;
    localparam logic [DW-1:0] PC_STEP = {{(DW-1){1'b0}}, 1'b1};

    logic            r_valid  [DEPTH];
    logic [TAGW-1:0] r_tag    [DEPTH];
    logic [DW-1:0]   r_target [DEPTH];
    ctr_e            r_ctr    [DEPTH];

    logic            r_pred_taken_d;
    logic [DW-1:0]   r_pred_target_d;

    logic [IDXW-1:0] w_f_idx;
    logic [TAGW-1:0] w_f_tag;
    logic            w_f_hit;
    logic [IDXW-1:0] w_u_idx;
    logic [TAGW-1:0] w_u_tag;
    logic            w_u_hit;
    logic            w_upd_en;
    ctr_e            w_ctr_next;

    // Fetch lookup reads registered state only, so a same-cycle update is invisible.
    assign w_f_idx    = PCF[IDXW-1:0];
    assign w_f_tag    = PCF[DW-1:IDXW];
    assign w_f_hit    = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    assign PredTakenF = w_f_hit && ctr_predicts_taken(r_ctr[w_f_idx]);
    assign PredPCF    = PredTakenF ? r_target[w_f_idx] : PCPlus1F;

    assign w_upd_en = BranchD && !StallD;
    assign w_u_idx  = PCD[IDXW-1:0];
    assign w_u_tag  = PCD[DW-1:IDXW];
    assign w_u_hit  = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);

    bp_sat_counter u_sat_counter (
        .i_ctr   (r_ctr[w_u_idx]),
        .i_taken (TakenD),
        .o_ctr   (w_ctr_next)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= SNT;
            end
        end else if (w_upd_en) begin
            if (w_u_hit) begin
                r_ctr[w_u_idx] <= w_ctr_next;
                if (TakenD) r_target[w_u_idx] <= TargetD;
            end else if (TakenD) begin
                r_valid[w_u_idx]  <= 1'b1;
                r_tag[w_u_idx]    <= w_u_tag;
                r_target[w_u_idx] <= TargetD;
                r_ctr[w_u_idx]    <= CTR_ALLOC;
            end
        end
    end

    // F/D prediction register; flush takes priority over stall.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_pred_taken_d  <= 1'b0;
            r_pred_target_d <= '0;
        end else if (FlushD) begin
            r_pred_taken_d  <= 1'b0;
            r_pred_target_d <= '0;
        end else if (!StallD) begin
            r_pred_taken_d  <= PredTakenF;
            r_pred_target_d <= PredPCF;
        end
    end

    assign MispredictD = w_upd_en &&
                         ((TakenD != r_pred_taken_d) ||
                          (TakenD && (TargetD != r_pred_target_d)));
    assign RecoverPCD  = TakenD ? TargetD : (PCD + PC_STEP);

`ifdef BP_STATS_EN
    logic [31:0] r_br_count;
    logic [31:0] r_miss_count;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_br_count   <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_upd_en)    r_br_count   <= sat_inc32(r_br_count);
            if (MispredictD) r_miss_count <= sat_inc32(r_miss_count);
        end
    end

    assign BrCount   = r_br_count;
    assign MissCount = r_miss_count;
`else
    assign BrCount   = '0;
    assign MissCount = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, hand
// sequences for reset/statistics, and randomized traffic against a model.
module tb_branch_predictor;

    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          Clk = 1'b0;
    logic          Rst;
    logic [DW-1:0] PCF, PCPlus1F, PredPCF, TargetD, PCD, RecoverPCD;
    logic          PredTakenF, StallD, FlushD, BranchD, TakenD, MispredictD;
    logic [31:0]   BrCount, MissCount;

    always #5 Clk = ~Clk;

    branch_predictor #(.DW(DW), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Rst(Rst),
        .PCF(PCF), .PCPlus1F(PCPlus1F),
        .PredTakenF(PredTakenF), .PredPCF(PredPCF),
        .StallD(StallD), .FlushD(FlushD),
        .BranchD(BranchD), .TakenD(TakenD), .TargetD(TargetD), .PCD(PCD),
        .MispredictD(MispredictD), .RecoverPCD(RecoverPCD),
        .BrCount(BrCount), .MissCount(MissCount)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the BTB as plain arrays, counters as integers 0..3.
    bit          m_valid [DEPTH];
    int unsigned m_tag   [DEPTH];
    int unsigned m_tgt   [DEPTH];
    int          m_ctr   [DEPTH];
    bit          m_pt_d;
    int unsigned m_ptgt_d;
    int unsigned m_br, m_miss;

    typedef struct {
        logic [31:0] pcf;
        bit          stall, flush, br, tk;
        logic [31:0] tgt, pcd;
        bit          use_exp;
        bit          e_pt;
        logic [31:0] e_ppc;
        bit          e_misp;
        logic [31:0] e_rec;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
        end
        m_pt_d = 0; m_ptgt_d = 0; m_br = 0; m_miss = 0;
    endfunction

    function automatic vec_t mk(input logic [31:0] pcf, input bit st, input bit fl,
                                input bit br, input bit tk, input logic [31:0] tgt,
                                input logic [31:0] pcd, input bit ept,
                                input logic [31:0] eppc, input bit emisp,
                                input logic [31:0] erec);
        vec_t v;
        v.pcf = pcf; v.stall = st; v.flush = fl; v.br = br; v.tk = tk;
        v.tgt = tgt; v.pcd = pcd; v.use_exp = 1;
        v.e_pt = ept; v.e_ppc = eppc; v.e_misp = emisp; v.e_rec = erec;
        return v;
    endfunction

    task automatic drive_idle();
        PCF = 0; PCPlus1F = 1; StallD = 0; FlushD = 0;
        BranchD = 0; TakenD = 0; TargetD = 0; PCD = 0;
    endtask

    // One pipeline cycle: drive after the edge, check at negedge, advance model.
    task automatic step(input vec_t v, input string nm);
        int          idx;
        bit          hit, ept, upd, emisp;
        int unsigned epc, erec;
        PCF = v.pcf; PCPlus1F = v.pcf + 1; StallD = v.stall; FlushD = v.flush;
        BranchD = v.br; TakenD = v.tk; TargetD = v.tgt; PCD = v.pcd;
        @(negedge Clk);
        idx   = v.pcf % DEPTH;
        hit   = m_valid[idx] && (m_tag[idx] == v.pcf / DEPTH);
        ept   = hit && (m_ctr[idx] >= 2);
        epc   = ept ? m_tgt[idx] : v.pcf + 1;
        upd   = v.br && !v.stall;
        emisp = upd && ((v.tk != m_pt_d) || (v.tk && (v.tgt != m_ptgt_d)));
        erec  = v.tk ? v.tgt : v.pcd + 1;
        check({nm, ".pred_taken"}, 32'(PredTakenF), 32'(ept));
        check({nm, ".pred_pc"}, PredPCF, epc);
        check({nm, ".mispredict"}, 32'(MispredictD), 32'(emisp));
        check({nm, ".recover_pc"}, RecoverPCD, erec);
        if (v.use_exp) begin
            check({nm, ".tbl_pred_taken"}, 32'(PredTakenF), 32'(v.e_pt));
            check({nm, ".tbl_pred_pc"}, PredPCF, v.e_ppc);
            check({nm, ".tbl_mispredict"}, 32'(MispredictD), 32'(v.e_misp));
            check({nm, ".tbl_recover_pc"}, RecoverPCD, v.e_rec);
        end
`ifdef BP_STATS_EN
        check({nm, ".br_count"}, BrCount, m_br);
        check({nm, ".miss_count"}, MissCount, m_miss);
`else
        check({nm, ".br_count"}, BrCount, 0);
        check({nm, ".miss_count"}, MissCount, 0);
`endif
        if (upd) m_br++;
        if (emisp) m_miss++;
        if (v.flush) begin
            m_pt_d = 0; m_ptgt_d = 0;
        end else if (!v.stall) begin
            m_pt_d = ept; m_ptgt_d = epc;
        end
        if (upd) begin
            idx = v.pcd % DEPTH;
            if (m_valid[idx] && (m_tag[idx] == v.pcd / DEPTH)) begin
                m_ctr[idx] = v.tk ? ((m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1)
                                  : ((m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1);
                if (v.tk) m_tgt[idx] = v.tgt;
            end else if (v.tk) begin
                m_valid[idx] = 1; m_tag[idx] = v.pcd / DEPTH;
                m_tgt[idx] = v.tgt; m_ctr[idx] = 2;
            end
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst = 1'b0;
        drive_idle();
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        model_reset();
    endtask

    vec_t tbl[24];
    vec_t rv;

    initial begin
        tbl[0]  = mk(5,     0,0,0,0,0,    0,     0,6,    0,1);
        tbl[1]  = mk(0,     0,0,1,0,0,    5,     0,1,    0,6);
        tbl[2]  = mk('h13,  0,0,1,1,'h40, 'h13,  0,'h14, 1,'h40);
        tbl[3]  = mk('h13,  0,0,0,0,0,    0,     1,'h40, 0,1);
        tbl[4]  = mk('h13,  0,0,1,1,'h40, 'h13,  1,'h40, 0,'h40);
        tbl[5]  = mk('h13,  0,0,1,1,'h40, 'h13,  1,'h40, 0,'h40);
        tbl[6]  = mk('h13,  0,0,1,1,'h40, 'h13,  1,'h40, 0,'h40);
        tbl[7]  = mk('h13,  0,0,1,0,0,    'h13,  1,'h40, 1,'h14);
        tbl[8]  = mk('h13,  0,0,0,0,0,    0,     1,'h40, 0,1);
        tbl[9]  = mk('h13,  0,0,1,0,0,    'h13,  1,'h40, 1,'h14);
        tbl[10] = mk('h13,  0,0,0,0,0,    0,     0,'h14, 0,1);
        tbl[11] = mk('h23,  0,0,1,1,'h80, 'h23,  0,'h24, 1,'h80);
        tbl[12] = mk('h13,  0,0,0,0,0,    0,     0,'h14, 0,1);
        tbl[13] = mk('h23,  0,0,0,0,0,    0,     1,'h80, 0,1);
        tbl[14] = mk(0,     0,0,1,1,'h90, 'h23,  0,1,    1,'h90);
        tbl[15] = mk('h23,  0,0,0,0,0,    0,     1,'h90, 0,1);
        tbl[16] = mk(0,     1,0,1,1,'h55, 5,     0,1,    0,'h55);
        tbl[17] = mk(5,     0,0,1,1,'h90, 'h23,  0,6,    0,'h90);
        tbl[18] = mk('h23,  0,0,0,0,0,    0,     1,'h90, 0,1);
        tbl[19] = mk(0,     1,1,0,0,0,    0,     0,1,    0,1);
        tbl[20] = mk(0,     0,0,1,0,0,    'h30,  0,1,    0,'h31);
        tbl[21] = mk('h23,  0,0,0,0,0,    0,     1,'h90, 0,1);
        tbl[22] = mk(0,     0,1,1,1,'h90, 'h23,  0,1,    0,'h90);
        tbl[23] = mk(0,     0,0,1,1,'h90, 'h23,  0,1,    1,'h90);

        // Reset state: predictor transparent while Rst is low.
        Rst = 1'b0;
        drive_idle();
        PCF = 5; PCPlus1F = 6;
        #1;
        check("reset.pred_taken", 32'(PredTakenF), 0);
        check("reset.pred_pc", PredPCF, 6);
        check("reset.br_count", BrCount, 0);
        check("reset.miss_count", MissCount, 0);
        do_reset();

        for (int i = 0; i < 24; i++) step(tbl[i], $sformatf("vec%0d", i));
        drive_idle();
`ifdef BP_STATS_EN
        check("table.br_count", BrCount, 13);
        check("table.miss_count", MissCount, 6);
`else
        check("table.br_count", BrCount, 0);
        check("table.miss_count", MissCount, 0);
`endif

        // Four branches, two of them mispredicted, then asynchronous reset.
        do_reset();
        rv = mk(0, 0,0,1,1,'h40,'h13, 0,0,0,0); rv.use_exp = 0; step(rv, "st0");
        rv = mk(0, 0,0,1,0,0,   'h07, 0,0,0,0); rv.use_exp = 0; step(rv, "st1");
        rv = mk(0, 0,0,1,1,'h40,'h13, 0,0,0,0); rv.use_exp = 0; step(rv, "st2");
        rv = mk(0, 0,0,1,0,0,   'h08, 0,0,0,0); rv.use_exp = 0; step(rv, "st3");
        drive_idle();
`ifdef BP_STATS_EN
        check("stats.br_count", BrCount, 4);
        check("stats.miss_count", MissCount, 2);
`else
        check("stats.br_count", BrCount, 0);
        check("stats.miss_count", MissCount, 0);
`endif
        PCF = 'h13; PCPlus1F = 'h14;
        #1;
        check("pre_reset.pred_taken", 32'(PredTakenF), 1);
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        check("async_reset.br_count", BrCount, 0);
        check("async_reset.miss_count", MissCount, 0);
        check("async_reset.pred_taken", 32'(PredTakenF), 0);
        check("async_reset.pred_pc", PredPCF, 'h14);
        // An allocating branch presented across an edge while in reset is discarded.
        BranchD = 1; TakenD = 1; PCD = 'h05; TargetD = 'h77;
        @(posedge Clk);
        #1;
        drive_idle();
        @(negedge Clk);
        Rst = 1'b1;
        PCF = 'h05; PCPlus1F = 'h06;
        #1;
        check("reset_discard.pred_taken", 32'(PredTakenF), 0);
        check("reset_discard.pred_pc", PredPCF, 'h06);
        @(posedge Clk);
        #1;
        model_reset();

        // Randomized traffic over a small PC range to force hits and aliasing.
        for (int i = 0; i < 3000; i++) begin
            rv.pcf     = $urandom_range(0, 63);
            rv.stall   = ($urandom_range(0, 9) < 2);
            rv.flush   = ($urandom_range(0, 9) == 0);
            rv.br      = ($urandom_range(0, 9) < 6);
            rv.tk      = ($urandom_range(0, 9) < 6);
            rv.tgt     = $urandom_range(0, 255);
            rv.pcd     = $urandom_range(0, 63);
            rv.use_exp = 0;
            rv.e_pt = 0; rv.e_ppc = 0; rv.e_misp = 0; rv.e_rec = 0;
            step(rv, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised fetch-stage branch predictor for the five-stage pipeline: a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters. It replaces the current static predict-not-taken path, which takes a flush on every taken branch resolved in decode. The block predicts next-PC in fetch and carries the prediction into decode in step with the F/D pipeline register. When decode resolves the branch, the block detects a misprediction and supplies the recovery PC.

## Interface
- DW, 32, datapath/PC width (PC is word-addressed, increments by 1)
- DEPTH, 16, BTB entries; power of two, 2..256
- IDXW, $clog2(DEPTH), index width; derived, not overridden
- Clk  in  1  clock, rising edge
- Rst  in  1  asynchronous, active-low reset
- PCF  in  DW  fetch PC
- PCPlus1F  in  DW  PCF+1
- PredTakenF  out  1  predict taken this cycle (combinational from PCF and current state)
- PredPCF  out  DW  predicted next PC: BTB target if PredTakenF, else PCPlus1F
- StallD  in  1  hold F/D prediction register
- FlushD  in  1  clear F/D prediction register; wins over StallD
- BranchD  in  1  decode holds a resolved branch this cycle
- TakenD  in  1  resolved direction
- TargetD  in  DW  resolved taken target (PCBranchD)
- PCD  in  DW  PC of the decode instruction
- MispredictD  out  1  prediction wrong; pipeline must flush F/D and redirect
- RecoverPCD  out  DW  correct next PC: TargetD if TakenD, else PCD+1
- BrCount, MissCount  out  32 each  statistics (see Configuration)

## Operation
- Entry: valid, tag = PC[DW-1:IDXW], target[DW-1:0], ctr[1:0]. Index = PC[IDXW-1:0].
- Lookup (F): hit = valid & tag match; PredTakenF = hit & ctr[1].
- F/D register: PredTakenD, PredTargetD. Loads PredTakenF/PredPCF when !StallD. Cleared to 0 on FlushD.
- MispredictD = BranchD & !StallD & ((TakenD != PredTakenD) | (TakenD & TargetD != PredTargetD)).
- Update on BranchD & !StallD, at index PCD[IDXW-1:0]:
  - hit: ctr saturating +1 if TakenD, -1 if not (3 stays 3, 0 stays 0). Target rewritten when TakenD.
  - miss & TakenD: allocate. valid=1, tag, target=TargetD, ctr=2 (weakly taken). Evicts any prior occupant.
  - miss & !TakenD: no change.
- A non-branch (BranchD=0) never updates the BTB or counters.

## Timing
- Lookup: zero-cycle combinational read of registered state.
- Update: written on the Clk edge ending the resolve cycle, and visible to lookups from the next cycle.
- Same-cycle lookup and update of the same index: the lookup sees the pre-update state.
- F-to-D prediction latency: 1 cycle. MispredictD and RecoverPCD are combinational in D.
- Reset (Rst low, any time, asynchronous): all valid=0, ctr=0, target=0; PredTakenD=0, PredTargetD=0; statistics=0.
  - While in reset, PredTakenF=0 and PredPCF=PCPlus1F.
  - Reset mid-update discards the update.
- StallD=1 freezes the D register and suppresses both update and MispredictD.

## Configuration
- BP_STATS_EN defined:
  - BrCount increments on each update-qualified branch.
  - MissCount increments on each MispredictD.
  - Both saturate at 32'hFFFFFFFF.
- BP_STATS_EN undefined: no counter flops; BrCount and MissCount tied to 0.

## Structure
- Package bp_pkg holds:
  - counter encodings SNT=0, WNT=1, WT=2, ST=3
  - CTR_ALLOC = WT
  - the BTB entry struct, parameterised by DW/IDXW through localparams
- Sub-module bp_sat_counter is natural: a 2-bit saturating up/down counter, combinational next-state function.
- Top instantiates its logic once per update path; no per-entry instances.

## Test plan
- Reset, then PCF=5 → PredTakenF=0, PredPCF=6. Then BranchD=1, TakenD=0, PCD=5 → MispredictD=0, BTB unchanged.
- Taken miss: PCD=0x13, TakenD=1, TargetD=0x40 → MispredictD=1, RecoverPCD=0x40. Next cycle PCF=0x13 → PredTakenF=1, PredPCF=0x40.
- Saturation: resolve PC 0x13 taken ×3 → ctr=3. Then not-taken ×1 → still predicts taken (ctr=2). Not-taken again → ctr=1, PredTakenF=0.
- Alias/eviction, DEPTH=16: allocate 0x13→0x40, then taken 0x23→0x80. Lookup 0x13 misses; lookup 0x23 gives 0x80.
- Stall/flush: StallD=1 with BranchD=1 mispredicting → MispredictD=0, no update. FlushD=1 with StallD=1 → PredTakenD=0.
- With BP_STATS_EN: 4 branches, 2 mispredicts → BrCount=4, MissCount=2. Asserting Rst mid-run → both 0 immediately.
